// File: rtl/hit_counter_display_if.sv
// Bundles the hit-counter control inputs and display/status outputs.
// The master side (board top or bench) drives hit/clear; the slave side is the counter.
interface hit_counter_display_if;
    logic       hit;
    logic       clear;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [7:0] count;
    logic       ovf;
    logic       led;

    modport master (
        output hit,
        output clear,
        input  hex0,
        input  hex1,
        input  count,
        input  ovf,
        input  led
    );

    modport slave (
        input  hit,
        input  clear,
        output hex0,
        output hex1,
        output count,
        output ovf,
        output led
    );
endinterface

// File: rtl/hit_counter_display.sv
// Counts rising edges of the "1101" detector output as a 2-digit BCD tally,
// shows it on two 7-seg digits and stretches each hit into an LED pulse.
// Build option: define HIT_COUNTER_SATURATE_EN to hold at 99 instead of wrapping to 00.
module hit_counter_display #(
    parameter logic [3:0] STRETCH = 4'd4
) (
    input  logic                  clk,
    input  logic                  reset,
    hit_counter_display_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stretch_state_t;

    logic           hit_q_r;
    logic           hit_edge_s;
    logic [7:0]     count_r;
    logic [7:0]     count_next_s;
    logic           ovf_r;
    logic           ovf_next_s;
    stretch_state_t state_r;
    stretch_state_t state_next_s;
    logic [3:0]     timer_r;
    logic [3:0]     timer_next_s;

    // Active-low 7-seg glyph for one BCD digit; anything else blanks the digit.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // hit_q follows hit even during clear so a level held across clear is not recounted.
    assign hit_edge_s = bus.hit & ~hit_q_r;

    // Delayed copy of hit for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q_r <= 1'b0;
        end else begin
            hit_q_r <= bus.hit;
        end
    end

    // BCD tally and sticky overflow next-state; clear wins over a coincident edge.
    always_comb begin
        count_next_s = count_r;
        ovf_next_s   = ovf_r;
        if (bus.clear) begin
            count_next_s = 8'h00;
            ovf_next_s   = 1'b0;
        end else if (hit_edge_s) begin
            if (count_r[3:0] < 4'd9) begin
                count_next_s = {count_r[7:4], count_r[3:0] + 4'd1};
            end else if (count_r[7:4] < 4'd9) begin
                count_next_s = {count_r[7:4] + 4'd1, 4'd0};
            end else begin
`ifdef HIT_COUNTER_SATURATE_EN
                count_next_s = 8'h99;
`else
                count_next_s = 8'h00;
`endif
                ovf_next_s   = 1'b1;
            end
        end else begin
            count_next_s = count_r;
            ovf_next_s   = ovf_r;
        end
    end

    // Tally and overflow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 8'h00;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    // Stretcher next-state: an edge (re)loads the timer, HOLD counts down to 0 then leaves.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        if (bus.clear) begin
            state_next_s = ST_IDLE;
            timer_next_s = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hit_edge_s) begin
                        state_next_s = ST_HOLD;
                        timer_next_s = STRETCH - 4'd1;
                    end else begin
                        state_next_s = ST_IDLE;
                        timer_next_s = timer_r;
                    end
                end
                ST_HOLD: begin
                    if (hit_edge_s) begin
                        state_next_s = ST_HOLD;
                        timer_next_s = STRETCH - 4'd1;
                    end else if (timer_r != 4'd0) begin
                        state_next_s = ST_HOLD;
                        timer_next_s = timer_r - 4'd1;
                    end else begin
                        state_next_s = ST_IDLE;
                        timer_next_s = 4'd0;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    timer_next_s = 4'd0;
                end
            endcase
        end
    end

    // Stretcher state and timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            timer_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
        end
    end

    assign bus.count = count_r;
    assign bus.ovf   = ovf_r;
    assign bus.led   = (state_r == ST_HOLD);
    assign bus.hex0  = seg7_decode(count_r[3:0]);
    assign bus.hex1  = seg7_decode(count_r[7:4]);

endmodule

// File: tb/tb_hit_counter_display.sv
// Directed bench for hit_counter_display: a per-cycle vector table plus
// hand-written sequences for digit carry, overflow at 99 and asynchronous reset.
module tb_hit_counter_display;

    typedef struct {
        logic       hit;
        logic       clear;
        logic [7:0] exp_count;
        logic       exp_ovf;
        logic       exp_led;
    } vec_t;

    logic CLOCK_50;
    logic reset;
    int   errors;
    int   checks;
    logic [6:0] seg_tab [10];
    vec_t vecs [24];

    hit_counter_display_if bus ();

    hit_counter_display #(.STRETCH(4'd4)) dut (
        .clk   (CLOCK_50),
        .reset (reset),
        .bus   (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every output against an expected tally, flag and LED level.
    task automatic chk_all(input string tag, input logic [7:0] cnt, input logic ovf, input logic led);
        chk({tag, ".count"}, bus.count, cnt);
        chk({tag, ".ovf"}, {7'd0, bus.ovf}, {7'd0, ovf});
        chk({tag, ".led"}, {7'd0, bus.led}, {7'd0, led});
        chk({tag, ".hex0"}, {1'b0, bus.hex0}, {1'b0, seg_tab[cnt[3:0]]});
        chk({tag, ".hex1"}, {1'b0, bus.hex1}, {1'b0, seg_tab[cnt[7:4]]});
    endtask

    // Drive inputs on the falling edge, then return just after the next rising edge.
    task automatic step(input logic h, input logic c);
        @(negedge CLOCK_50);
        bus.hit   = h;
        bus.clear = c;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;

        // idle; isolated hit (LED 4 cycles); hit held 5 cycles; retrigger; clear+edge
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'h03, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 8'h03, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 8'h04, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 8'h04, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 8'h04, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1};

        bus.hit   = 1'b0;
        bus.clear = 1'b0;
        reset     = 1'b0;
        #12;
        chk_all("reset", 8'h00, 1'b0, 1'b0);
        @(negedge CLOCK_50);
        reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].hit, vecs[i].clear);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ovf, vecs[i].exp_led);
        end

        // Bring the tally back to 00, then walk up to 09 and carry into 10.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk_all("clr", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) pulse();
        chk_all("at09", 8'h09, 1'b0, 1'b1);
        pulse();
        chk_all("at10", 8'h10, 1'b0, 1'b1);

        for (int i = 0; i < 89; i++) pulse();
        repeat (4) step(1'b0, 1'b0);
        chk_all("at99", 8'h99, 1'b0, 1'b0);

        step(1'b1, 1'b0);
`ifdef HIT_COUNTER_SATURATE_EN
        chk_all("ovf_edge", 8'h99, 1'b1, 1'b1);
`else
        chk_all("ovf_edge", 8'h00, 1'b1, 1'b1);
`endif
        step(1'b0, 1'b0);
        pulse();
`ifdef HIT_COUNTER_SATURATE_EN
        chk_all("ovf_sticky", 8'h99, 1'b1, 1'b1);
`else
        chk_all("ovf_sticky", 8'h01, 1'b1, 1'b1);
`endif
        step(1'b0, 1'b1);
        chk_all("ovf_clear", 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an LED hold, checked between clock edges.
        pulse();
        pulse();
        chk_all("pre_rst", 8'h02, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 1'b0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        step(1'b0, 1'b0);
        chk_all("post_rst", 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
